// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-and-add 16-bit multiplier sequencer that borrows an
// external Hack ALU as its only adder. Each iteration takes two cycles:
// ADD conditionally accumulates the multiplicand, DBL doubles it and
// shifts the multiplier right. Iteration stops as soon as the remaining
// multiplier bits are all zero, so latency tracks the top set bit of b.
module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic             alu_zx,
    output logic             alu_nx,
    output logic             alu_zy,
    output logic             alu_ny,
    output logic             alu_f,
    output logic             alu_no,
    input  logic [WIDTH-1:0] alu_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DBL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] product_q;
    logic             busy_q;
    logic             done_q;

    // ADD only uses the ALU when the current multiplier bit is set and
    // there is still work left; otherwise the ALU idles at constant 0.
    logic add_en;
    logic dbl_en;

    assign add_en = (state_q == S_ADD) && (mplier_q != '0) && mplier_q[0];
    assign dbl_en = (state_q == S_DBL);

    // ALU operand/control drive: x+y while accumulating or doubling, else constant 0
    always_comb begin
        alu_x  = '0;
        alu_y  = '0;
        alu_zx = 1'b1;
        alu_nx = 1'b0;
        alu_zy = 1'b1;
        alu_ny = 1'b0;
        alu_f  = 1'b1;
        alu_no = 1'b0;
        if (add_en) begin
            alu_x  = acc_q;
            alu_y  = mcand_q;
            alu_zx = 1'b0;
            alu_zy = 1'b0;
        end else if (dbl_en) begin
            alu_x  = mcand_q;
            alu_y  = mcand_q;
            alu_zx = 1'b0;
            alu_zy = 1'b0;
        end
    end

    // Sequencer FSM with registered busy/done/product
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        acc_q    <= '0;
                        mcand_q  <= a;
                        mplier_q <= b;
                        busy_q   <= 1'b1;
                        state_q  <= S_ADD;
                    end
                end
                S_ADD: begin
                    if (mplier_q == '0) begin
                        product_q <= acc_q;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        if (mplier_q[0]) acc_q <= alu_out;
                        state_q <= S_DBL;
                    end
                end
                S_DBL: begin
                    mcand_q  <= alu_out;
                    mplier_q <= mplier_q >> 1;
                    state_q  <= S_ADD;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: models the Hack ALU as the external adder and
// checks products, done latency, busy/done shape and abort behaviour.
module tb_alu_mul_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] product;
    logic [W-1:0] alu_x, alu_y, alu_out;
    logic         alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    alu_mul_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product),
        .alu_x(alu_x), .alu_y(alu_y),
        .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy),
        .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
        .alu_out(alu_out)
    );

    // Hack ALU reference, combinational
    always_comb begin
        logic [W-1:0] x, y, o;
        x = alu_x;
        y = alu_y;
        if (alu_zx) x = '0;
        if (alu_nx) x = ~x;
        if (alu_zy) y = '0;
        if (alu_ny) y = ~y;
        o = alu_f ? (x + y) : (x & y);
        if (alu_no) o = ~o;
        alu_out = o;
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] prod;
        int           lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one multiply; mode 0 = plain, 1 = re-pulse start at edge 3
    task automatic run_op(input vec_t v, input int mode);
        int  edges;
        bit  busy_ok, zero_ok;
        a = v.a; b = v.b; start = 1'b1;
        step();
        start = 1'b0;
        edges = 1;
        busy_ok = 1; zero_ok = 1;
        while (!done && edges < 100) begin
            if (busy !== 1'b1) busy_ok = 0;
            if (!(alu_zx && alu_zy && alu_f)) zero_ok = 0;
            if (mode == 1 && edges == 2) begin
                start = 1'b1; a = 16'd9; b = 16'd9;
            end
            step();
            edges++;
            if (mode == 1 && edges == 3) begin
                start = 1'b0; a = '0; b = '0;
            end
        end
        if (!(alu_zx && alu_zy && alu_f)) zero_ok = 0;
        chk("done_seen", done, 1'b1);
        chk("latency", edges, v.lat);
        chk("busy_during", busy_ok, 1'b1);
        chk("busy_at_done", busy, 1'b1);
        chk("product", product, v.prod);
        if (v.b == '0) chk("alu_const0", zero_ok, 1'b1);
        step();
        chk("done_pulse_1cyc", done, 1'b0);
        chk("busy_after", busy, 1'b0);
        chk("product_held", product, v.prod);
    endtask

    vec_t vecs[8];

    initial begin
        int seen_done;
        vec_t v;

        vecs[0] = '{16'd3,      16'd5,      16'h000F, 8};
        vecs[1] = '{16'd1234,   16'd0,      16'h0000, 2};
        vecs[2] = '{16'hFFF9,   16'd6,      16'hFFD6, 8};
        vecs[3] = '{16'd300,    16'd300,    16'h5F90, 20};
        vecs[4] = '{16'd3,      16'h8000,   16'h8000, 34};
        vecs[5] = '{16'd2,      16'd2,      16'h0004, 6};
        vecs[6] = '{16'hFFFF,   16'hFFFF,   16'h0001, 34};
        vecs[7] = '{16'h7FFF,   16'd2,      16'hFFFE, 6};

        // reset, with start held high: reset must win
        reset = 1'b1; start = 1'b1; a = 16'd7; b = 16'd7;
        step();
        step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_product", product, 16'h0);
        chk("rst_alu_zx", alu_zx, 1'b1);
        start = 1'b0;
        reset = 1'b0;
        step();

        for (int i = 0; i < 8; i++) run_op(vecs[i], 0);

        // start re-pulsed mid-operation is ignored; inputs changed after acceptance
        v = '{16'd5, 16'd7, 16'd35, 8};
        run_op(v, 1);

        // reset at edge 3 aborts; no done pulse afterwards
        a = 16'd5; b = 16'd7; start = 1'b1;
        step();
        start = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_product", product, 16'h0);
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (done || busy) seen_done = 1;
            step();
        end
        chk("abort_no_done", seen_done, 0);

        v = '{16'd2, 16'd3, 16'd6, 6};
        run_op(v, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle 16-bit multiplier controller that computes a product using only the Hack ALU as its adder.
- It drives the ALU operand and control inputs each cycle and captures the ALU output into its own registers, using shift-and-add.
- It sits beside the ALU in the Hack datapath and serves as a reusable sequencer for multiply, which the ALU cannot do in one pass.
- The ALU is instantiated outside this block; this block only drives and reads it.

Parameters:
- WIDTH, 16, operand/product/ALU data width. It must match the ALU width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only when busy=0.
- a  input  WIDTH  multiplicand, two's complement.
- b  input  WIDTH  multiplier, two's complement.
- busy  output  1  high from the edge after start is accepted until done is asserted.
- done  output  1  single-cycle pulse; product is valid.
- product  output  WIDTH  low WIDTH bits of a*b; held until the next accepted start.
- alu_x  output  WIDTH  ALU x operand.
- alu_y  output  WIDTH  ALU y operand.
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  output  1 each  ALU control bits.
- alu_out  input  WIDTH  ALU result, combinational from the alu_* drives.

Behaviour:
- Reset (synchronous, active-high) values:
  - State goes to IDLE.
  - busy=0, done=0, product=0.
  - Internal registers acc, mcand and mplier are cleared to 0.
- States: IDLE, ADD, DBL, DONE.
- IDLE:
  - busy=0.
  - If start=1 at a rising edge: acc<=0, mcand<=a, mplier<=b, go to ADD.
- ADD (busy=1):
  - If mplier==0: go to DONE and set product<=acc.
  - Else if mplier[0]==1: drive alu_x=acc, alu_y=mcand with controls zx=0,nx=0,zy=0,ny=0,f=1,no=0 (x+y); acc<=alu_out; go to DBL.
  - Else (mplier[0]==0): acc is held; go to DBL.
- DBL (busy=1):
  - Drive alu_x=mcand, alu_y=mcand with x+y controls; mcand<=alu_out.
  - mplier<=mplier>>1 (logical shift, zero fill).
  - Go to ADD.
- DONE:
  - done=1, busy=1 for exactly one cycle; then go to IDLE.
- ALU drive in IDLE, DONE, and ADD without an add: alu_x=0, alu_y=0, controls zx=1,nx=0,zy=1,ny=0,f=1,no=0 (constant 0).
  - alu_* outputs are combinational from state and registers.
- Arithmetic:
  - All sums wrap modulo 2^WIDTH.
  - The result equals the low WIDTH bits of the signed or unsigned product; b is processed as unsigned bits.
- Latency:
  - Let k = (index of the highest set bit of b) + 1, with k=0 when b=0.
  - done is high in the cycle after the (2k+2)th rising edge counted from the edge that accepted start.
  - The next start can be accepted on the edge where done=1 is seen in IDLE, i.e. the cycle after done.
- Boundary rules:
  - start while busy=1 (including during DONE) is ignored, with no queueing.
  - a and b are sampled only at acceptance; later changes have no effect.
  - b=0: no ALU adds occur; done follows after 2 edges; product=0.
  - b=0x8000: 16 iterations, the maximum latency of 34 edges.
  - reset asserted in any state aborts the operation and applies the reset values on that edge; no done pulse follows.
  - reset and start high on the same edge: reset wins.

Test Plan:
- reset, then a=3, b=5, start pulse -> done after 8 edges, product=15 (0x000F), busy high throughout, done high 1 cycle.
- a=1234, b=0 -> done after 2 edges, product=0; alu_f=1, alu_zx=1, alu_zy=1 in every cycle.
- a=-7 (0xFFF9), b=6 -> done after 8 edges, product=0xFFD6 (-42); a=300, b=300 -> done after 20 edges, product=0x5F90 (wrap of 90000).
- a=3, b=0x8000 -> done after 34 edges, product=0x8000; then immediately a=2, b=2 -> product=4 with no stale acc.
- a=5, b=7, start; start re-pulsed with a=9, b=9 at edge 3 -> ignored, product=35.
- a=5, b=7, start; reset at edge 3 -> busy=0, done=0, product=0 next cycle and no done pulse.
- After that reset: a=2, b=3, start -> product=6.
